// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: RAW-hazard stalls, taken-branch flushes and data-memory waits
// for the 5-stage core, with saturating stall/flush statistics and a sticky memory-timeout flag.
module hazard_stall_ctrl #(
    parameter int unsigned BR_FLUSH_CYC = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       src1,
    input  logic [4:0]       src2,
    input  logic             two_src,
    input  logic             fwd_en,
    input  logic [4:0]       ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_r_en,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {StRun, StBrFlush, StMemWait} state_t;

    localparam logic [2:0] FlushReload = 3'(BR_FLUSH_CYC - 1);
    localparam logic [7:0] TimeoutVal  = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d, saved_q, saved_d, cur_state;
    logic [2:0]       rem_q, rem_d, saved_rem_q, saved_rem_d, cur_rem;
    logic [7:0]       wait_q, wait_d;
    logic             pend_q, pend_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             ex_hit, mem_hit, hazard, mem_wait, br_eff;

    always_comb begin
        ex_hit  = ex_wb_en && (ex_dest != 5'd0) &&
                  ((src1 == ex_dest) || (two_src && (src2 == ex_dest)));
        mem_hit = mem_wb_en && (mem_dest != 5'd0) &&
                  ((src1 == mem_dest) || (two_src && (src2 == mem_dest)));
        hazard  = fwd_en ? (ex_hit && ex_mem_r_en) : (ex_hit || mem_hit);
    end

    always_comb begin
        mem_wait     = mem_req && !mem_ready;
        // On the mem_ready cycle the controller behaves as the state it was in before the wait.
        cur_state    = (state_q == StMemWait) ? saved_q : state_q;
        cur_rem      = (state_q == StMemWait) ? saved_rem_q : rem_q;
        br_eff       = br_taken || pend_q;
        pc_freeze    = 1'b0;
        if_id_freeze = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        state_d      = state_q;
        saved_d      = saved_q;
        rem_d        = rem_q;
        saved_rem_d  = saved_rem_q;
        wait_d       = wait_q;
        pend_d       = pend_q;
        timeout_d    = timeout_q;
        stall_d      = stall_q;
        flush_d      = flush_q;
        if (mem_wait) begin
            pipe_freeze  = 1'b1;
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            if (state_q != StMemWait) begin
                saved_d     = state_q;
                saved_rem_d = rem_q;
            end
            state_d = StMemWait;
            if (wait_q != TimeoutVal) wait_d = wait_q + 8'd1;
            if (wait_d == TimeoutVal) timeout_d = 1'b1;
            if (br_taken) pend_d = 1'b1;
        end else begin
            wait_d = 8'd0;
            pend_d = 1'b0;
            if (br_eff) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (flush_q != {CNT_W{1'b1}}) flush_d = flush_q + 1'b1;
                state_d = (FlushReload != 3'd0) ? StBrFlush : StRun;
                rem_d   = FlushReload;
            end else if (cur_state == StBrFlush) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                rem_d       = cur_rem - 3'd1;
                state_d     = (rem_d == 3'd0) ? StRun : StBrFlush;
            end else begin
                state_d = StRun;
                if (hazard) begin
                    pc_freeze    = 1'b1;
                    if_id_freeze = 1'b1;
                    id_ex_flush  = 1'b1;
                    if (stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
                end
            end
        end
        if (rst) begin
            pc_freeze    = 1'b0;
            if_id_freeze = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            pipe_freeze  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            saved_q     <= StRun;
            rem_q       <= 3'd0;
            saved_rem_q <= 3'd0;
            wait_q      <= 8'd0;
            pend_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stall_q     <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            rem_q       <= rem_d;
            saved_rem_q <= saved_rem_d;
            wait_q      <= wait_d;
            pend_q      <= pend_d;
            timeout_q   <= timeout_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against a cycle model
// that tracks remaining flush cycles, wait length and a held branch.
module tb_hazard_stall_ctrl;
    localparam int unsigned BFC = 2;
    localparam int unsigned MT  = 4;
    localparam int unsigned CW  = 4;
    localparam int          SAT = (1 << CW) - 1;

    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] STALL = 5'b11010;
    localparam logic [4:0] FLUSH = 5'b00110;
    localparam logic [4:0] WAITV = 5'b11001;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] src1, src2, ex_dest, mem_dest;
    logic two_src, fwd_en, ex_wb_en, ex_mem_r_en, mem_wb_en, br_taken, mem_req, mem_ready;
    logic pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [4:0] ctl;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.BR_FLUSH_CYC(BFC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src), .fwd_en(fwd_en),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctl = {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze};

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: flush cycles still owed, current wait length, held branch, statistics.
    int m_left = 0, m_wait = 0, m_stall = 0, m_flush = 0;
    bit m_pend = 0, m_to = 0;
    int n_left, n_wait, n_stall, n_flush;
    bit n_pend, n_to;
    logic [4:0] exp_ctl;

    function automatic bit ref_hazard();
        logic [4:0] srcs[$];
        bit hit = 1'b0;
        srcs.push_back(src1);
        if (two_src) srcs.push_back(src2);
        foreach (srcs[i]) begin
            if (srcs[i] != 5'd0) begin
                if (ex_wb_en && srcs[i] == ex_dest && (!fwd_en || ex_mem_r_en)) hit = 1'b1;
                if (!fwd_en && mem_wb_en && srcs[i] == mem_dest) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    task automatic settle();
        @(negedge clk);
        n_left = m_left; n_wait = m_wait; n_stall = m_stall; n_flush = m_flush;
        n_pend = m_pend; n_to = m_to;
        if (rst) begin
            exp_ctl = NONE;
            n_left = 0; n_wait = 0; n_stall = 0; n_flush = 0; n_pend = 0; n_to = 0;
        end else if (mem_req && !mem_ready) begin
            exp_ctl = WAITV;
            n_wait  = m_wait + 1;
            n_to    = m_to || (n_wait >= MT);
            n_pend  = m_pend || br_taken;
        end else begin
            n_wait = 0;
            n_pend = 0;
            if (br_taken || m_pend) begin
                exp_ctl = FLUSH;
                n_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
                n_left  = BFC - 1;
            end else if (m_left > 0) begin
                exp_ctl = FLUSH;
                n_left  = m_left - 1;
            end else if (ref_hazard()) begin
                exp_ctl = STALL;
                n_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            end else begin
                exp_ctl = NONE;
            end
        end
    endtask

    task automatic commit();
        m_left = n_left; m_wait = n_wait; m_stall = n_stall; m_flush = n_flush;
        m_pend = n_pend; m_to = n_to;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        src1 = 0; src2 = 0; two_src = 0; fwd_en = 0; ex_dest = 0; ex_wb_en = 0;
        ex_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0; br_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1; settle(); commit();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1; mem_req = 1'b1; br_taken = 1'b1;
        settle();
        n_checks++; if (ctl !== NONE) begin n_fail++; $display("FAIL reset_ctl got=%b want=%b", ctl, NONE); end
        commit();
        settle();
        n_checks++; if ({mem_timeout, stall_cnt, flush_cnt} !== 9'd0) begin
            n_fail++; $display("FAIL reset_state got to=%b stall=%0d flush=%0d want 0", mem_timeout, stall_cnt, flush_cnt);
        end
        commit();
        rst = 1'b0; clear_in();
    endtask

    task automatic test_raw_nofwd();
        do_reset();
        src1 = 5; ex_dest = 5; ex_wb_en = 1;
        settle();
        n_checks++; if (ctl !== STALL) begin n_fail++; $display("FAIL raw_ex got=%b want=%b", ctl, STALL); end
        n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL raw_cnt0 got=%0d want=0", stall_cnt); end
        commit();
        src1 = 0; ex_dest = 0;
        settle();
        n_checks++; if (ctl !== NONE) begin n_fail++; $display("FAIL raw_r0 got=%b want=%b", ctl, NONE); end
        n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL raw_cnt1 got=%0d want=1", stall_cnt); end
        commit();
        ex_wb_en = 0; two_src = 1; src2 = 9; mem_dest = 9; mem_wb_en = 1;
        settle();
        n_checks++; if (ctl !== STALL) begin n_fail++; $display("FAIL raw_mem got=%b want=%b", ctl, STALL); end
        commit();
        two_src = 0;
        settle();
        n_checks++; if (ctl !== NONE) begin n_fail++; $display("FAIL raw_one_src got=%b want=%b", ctl, NONE); end
        commit();
    endtask

    task automatic test_load_use();
        do_reset();
        fwd_en = 1; ex_dest = 7; ex_wb_en = 1; ex_mem_r_en = 1; two_src = 1; src2 = 7; src1 = 3;
        settle();
        n_checks++; if (ctl !== STALL) begin n_fail++; $display("FAIL load_use got=%b want=%b", ctl, STALL); end
        commit();
        ex_mem_r_en = 0;
        settle();
        n_checks++; if (ctl !== NONE) begin n_fail++; $display("FAIL fwd_alu got=%b want=%b", ctl, NONE); end
        n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL load_cnt got=%0d want=1", stall_cnt); end
        commit();
    endtask

    task automatic test_branch();
        do_reset();
        br_taken = 1;
        settle();
        n_checks++; if (ctl !== FLUSH) begin n_fail++; $display("FAIL br_c1 got=%b want=%b", ctl, FLUSH); end
        commit();
        br_taken = 0; src1 = 6; ex_dest = 6; ex_wb_en = 1;
        settle();
        n_checks++; if (ctl !== FLUSH) begin n_fail++; $display("FAIL br_c2 got=%b want=%b", ctl, FLUSH); end
        n_checks++; if (flush_cnt !== 4'd1) begin n_fail++; $display("FAIL br_cnt got=%0d want=1", flush_cnt); end
        commit();
        clear_in();
        settle();
        n_checks++; if (ctl !== NONE) begin n_fail++; $display("FAIL br_c3 got=%b want=%b", ctl, NONE); end
        n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL br_nostall got=%0d want=0", stall_cnt); end
        commit();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++; if (ctl !== WAITV) begin n_fail++; $display("FAIL wait_c%0d got=%b want=%b", i, ctl, WAITV); end
            commit();
        end
        mem_ready = 1;
        settle();
        n_checks++; if (ctl !== NONE) begin n_fail++; $display("FAIL wait_ready got=%b want=%b", ctl, NONE); end
        commit();
        clear_in();
        settle();
        n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL wait_noto got=%b want=0", mem_timeout); end
        commit();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1;
        for (int i = 1; i <= 6; i++) begin
            settle();
            n_checks++; if (mem_timeout !== (i >= 5)) begin
                n_fail++; $display("FAIL to_c%0d got=%b want=%b", i, mem_timeout, i >= 5);
            end
            commit();
        end
        mem_ready = 1;
        settle();
        n_checks++; if (ctl !== NONE) begin n_fail++; $display("FAIL to_ready got=%b want=%b", ctl, NONE); end
        commit();
        clear_in();
        settle();
        n_checks++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky got=%b want=1", mem_timeout); end
        commit();
        rst = 1;
        settle(); commit();
        rst = 0;
        settle();
        n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_rst got=%b want=0", mem_timeout); end
        commit();
    endtask

    task automatic test_br_during_wait();
        do_reset();
        mem_req = 1; br_taken = 1;
        settle();
        n_checks++; if (ctl !== WAITV) begin n_fail++; $display("FAIL bw_wait got=%b want=%b", ctl, WAITV); end
        commit();
        br_taken = 0; mem_ready = 1;
        settle();
        n_checks++; if (ctl !== FLUSH) begin n_fail++; $display("FAIL bw_ready got=%b want=%b", ctl, FLUSH); end
        commit();
        clear_in();
        settle();
        n_checks++; if (ctl !== FLUSH || flush_cnt !== 4'd1) begin
            n_fail++; $display("FAIL bw_tail got=%b cnt=%0d want=%b cnt=1", ctl, flush_cnt, FLUSH);
        end
        commit();
    endtask

    task automatic test_br_hazard();
        do_reset();
        br_taken = 1; src1 = 4; ex_dest = 4; ex_wb_en = 1;
        settle();
        n_checks++; if (ctl !== FLUSH) begin n_fail++; $display("FAIL bh_same got=%b want=%b", ctl, FLUSH); end
        commit();
        br_taken = 0; rst = 1;
        settle();
        n_checks++; if (ctl !== NONE) begin n_fail++; $display("FAIL bh_rst got=%b want=%b", ctl, NONE); end
        commit();
        rst = 0;
        settle();
        n_checks++; if (ctl !== STALL) begin n_fail++; $display("FAIL bh_run got=%b want=%b", ctl, STALL); end
        n_checks++; if (flush_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
            n_fail++; $display("FAIL bh_cnt got flush=%0d stall=%0d want 0", flush_cnt, stall_cnt);
        end
        commit();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            src1        = 5'($urandom_range(0, 3));
            src2        = 5'($urandom_range(0, 3));
            ex_dest     = 5'($urandom_range(0, 3));
            mem_dest    = 5'($urandom_range(0, 3));
            two_src     = 1'($urandom);
            fwd_en      = 1'($urandom);
            ex_wb_en    = 1'($urandom);
            ex_mem_r_en = 1'($urandom);
            mem_wb_en   = 1'($urandom);
            br_taken    = ($urandom_range(0, 7) == 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            mem_ready   = ($urandom_range(0, 2) == 0);
            settle();
            n_checks++; if (ctl !== exp_ctl) begin n_fail++; $display("FAIL rnd_ctl i=%0d got=%b want=%b", i, ctl, exp_ctl); end
            n_checks++; if ({mem_timeout, stall_cnt, flush_cnt} !== {m_to, 4'(m_stall), 4'(m_flush)}) begin
                n_fail++; $display("FAIL rnd_state i=%0d got to=%b st=%0d fl=%0d want to=%b st=%0d fl=%0d",
                                   i, mem_timeout, stall_cnt, flush_cnt, m_to, m_stall, m_flush);
            end
            commit();
        end
        rst = 0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_raw_nofwd();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_br_during_wait();
        test_br_hazard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
